lycalo_trg_readout: RTL and testbench

- Consumer end of the layer-calorimeter trigger interface: LYCALOTRG / LYCALOQSUM in, time-stamped event words out.
- Detects rising edges of LYCALOTRG and captures the matching LYCALOQSUM with a free-running timestamp.
- Applies a programmable dead time after each capture.
- Buffers events in a FIFO and presents them on a valid/ready stream toward DAQ readout, with accept and drop counters for monitoring.

---
 rtl/lycalo_pkg.sv | 14 +
 rtl/lycalo_evt_fifo.sv | 69 ++++++
 rtl/lycalo_trg_readout.sv | 107 ++++++++++
 tb/tb_lycalo_trg_readout.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lycalo_pkg.sv
// Shared constants and types for the layer-calorimeter trigger readout.
// Event word layout: timestamp in the upper half, sign-extended charge sum in the lower half.
package lycalo_pkg;
    localparam int QSUM_W   = 29;
    localparam int TS_W     = 32;
    localparam int EVT_W    = 64;
    localparam int TS_LSB   = 32;
    localparam int QSUM_LSB = 0;

    typedef enum logic {
        IDLE = 1'b0,
        DEAD = 1'b1
    } state_t;
endpackage

// File: rtl/lycalo_evt_fifo.sv
// Synchronous first-word-fall-through FIFO. The head is kept in its own register so
// the output holds its last value when the FIFO drains and reads back 0 after reset.
module lycalo_evt_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 64
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic                       i_push,
    input  logic [W-1:0]               i_din,
    input  logic                       i_pop,
    output logic [W-1:0]               o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [W-1:0]  r_head;
    logic [AW-1:0] w_rd_nxt;
    logic          w_pop;
    logic          w_push;

    assign o_empty  = (r_level == '0);
    assign o_full   = (r_level == (AW+1)'(DEPTH));
    assign w_pop    = i_pop & ~o_empty;
    assign w_push   = i_push & (~o_full | w_pop);
    assign w_rd_nxt = r_rd_ptr + AW'(1);

    always_ff @(posedge CLK) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= w_rd_nxt;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
            // Next head comes from memory if already stored, else from the word arriving now.
            if (w_pop) begin
                if (r_level > (AW+1)'(1))
                    r_head <= r_mem[w_rd_nxt];
                else if (w_push)
                    r_head <= i_din;
            end else if (w_push && o_empty) begin
                r_head <= i_din;
            end
        end
    end

    assign o_dout  = r_head;
    assign o_level = r_level;
endmodule

// File: rtl/lycalo_trg_readout.sv
// Layer-calorimeter trigger consumer: edge-detects LYCALOTRG, time-stamps the charge sum,
// enforces a dead time after each capture and queues event words for DAQ readout.
module lycalo_trg_readout #(
    parameter int DEPTH  = 16,
    parameter int TS_W   = lycalo_pkg::TS_W,
    parameter int QSUM_W = lycalo_pkg::QSUM_W
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    input  logic                          ENABLE,
    input  logic [15:0]                   DEADTIME,
    input  logic                          LYCALOTRG,
    input  logic signed [QSUM_W-1:0]      LYCALOQSUM,
    output logic [lycalo_pkg::EVT_W-1:0]  EVT_DATA,
    output logic                          EVT_VALID,
    input  logic                          EVT_READY,
    output logic [$clog2(DEPTH):0]        FIFO_LEVEL,
    output logic [31:0]                   EVT_CNT,
    output logic [15:0]                   DROP_CNT
);
    import lycalo_pkg::*;

    function automatic logic [31:0] sext32(input logic [QSUM_W-1:0] v);
        logic [31:0] ext;
        ext = {32{v[QSUM_W-1]}};
        ext[QSUM_W-1:0] = v;
        return ext;
    endfunction

    logic [TS_W-1:0]  r_ts;
    logic             r_trg_d;
    state_t           r_state;
    logic [15:0]      r_dead;
    logic [31:0]      r_evt_cnt;
    logic [15:0]      r_drop_cnt;

    logic             w_edge;
    logic             w_capture;
    logic             w_fifo_ok;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic [EVT_W-1:0] w_word;

    assign w_edge    = LYCALOTRG & ~r_trg_d;
    assign w_capture = (r_state == IDLE) & w_edge & ENABLE;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_fifo_ok = ~w_full | (EVT_VALID & EVT_READY);
    assign w_push    = w_capture & w_fifo_ok;

    always_comb begin
        w_word = '0;
        w_word[TS_LSB +: 32]   = 32'(r_ts);
        w_word[QSUM_LSB +: 32] = sext32(LYCALOQSUM);
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_ts       <= '0;
            r_trg_d    <= 1'b1;
            r_state    <= IDLE;
            r_dead     <= '0;
            r_evt_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_ts    <= r_ts + TS_W'(1);
            r_trg_d <= LYCALOTRG;
            if (w_push)
                r_evt_cnt <= r_evt_cnt + 32'd1;
            if (w_capture && !w_fifo_ok && r_drop_cnt != 16'hFFFF)
                r_drop_cnt <= r_drop_cnt + 16'd1;
            case (r_state)
                IDLE: begin
                    if (w_capture && DEADTIME != 16'd0) begin
                        r_dead  <= DEADTIME;
                        r_state <= DEAD;
                    end
                end
                DEAD: begin
                    r_dead <= r_dead - 16'd1;
                    if (r_dead == 16'd1)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    lycalo_evt_fifo #(
        .DEPTH (DEPTH),
        .W     (EVT_W)
    ) u_fifo (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .i_push  (w_push),
        .i_din   (w_word),
        .i_pop   (EVT_READY),
        .o_dout  (EVT_DATA),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (FIFO_LEVEL)
    );

    assign EVT_VALID = ~w_empty;
    assign EVT_CNT   = r_evt_cnt;
    assign DROP_CNT  = r_drop_cnt;
endmodule

// File: tb/tb_lycalo_trg_readout.sv
// Directed bench for lycalo_trg_readout: expected words and counts are written out by hand.
module tb_lycalo_trg_readout;
    logic               clk;
    logic               rstn;
    logic               enable;
    logic [15:0]        deadtime;
    logic               trg;
    logic signed [28:0] qsum;
    logic [63:0]        evt_data;
    logic               evt_valid;
    logic               evt_ready;
    logic [4:0]         fifo_level;
    logic [31:0]        evt_cnt;
    logic [15:0]        drop_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    lycalo_trg_readout #(.DEPTH(16), .TS_W(32), .QSUM_W(29)) dut (
        .CLK        (clk),
        .RSTN       (rstn),
        .ENABLE     (enable),
        .DEADTIME   (deadtime),
        .LYCALOTRG  (trg),
        .LYCALOQSUM (qsum),
        .EVT_DATA   (evt_data),
        .EVT_VALID  (evt_valid),
        .EVT_READY  (evt_ready),
        .FIFO_LEVEL (fifo_level),
        .EVT_CNT    (evt_cnt),
        .DROP_CNT   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic pulse(input logic signed [28:0] q);
        trg  = 1'b1;
        qsum = q;
        step();
        trg  = 1'b0;
        step();
    endtask

    initial begin
        rstn      = 1'b0;
        enable    = 1'b1;
        deadtime  = 16'd0;
        trg       = 1'b0;
        qsum      = '0;
        evt_ready = 1'b0;

        // Reset state
        do_reset();
        chk("rst_valid", 64'(evt_valid), 64'd0);
        chk("rst_data",  evt_data,       64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_cnt",   64'(evt_cnt),   64'd0);
        chk("rst_drop",  64'(drop_cnt),  64'd0);

        // Single event at timestamp 5
        evt_ready = 1'b1;
        repeat (5) step();
        trg  = 1'b1;
        qsum = 29'sd100;
        step();
        chk("single_valid", 64'(evt_valid), 64'd1);
        chk("single_data",  evt_data, 64'h00000005_00000064);
        trg = 1'b0;
        step();
        chk("single_valid_off", 64'(evt_valid), 64'd0);
        chk("single_cnt",       64'(evt_cnt),   64'd1);
        chk("single_level",     64'(fifo_level), 64'd0);

        // Negative charge sum at timestamp 20
        do_reset();
        evt_ready = 1'b1;
        repeat (20) step();
        trg  = 1'b1;
        qsum = -29'sd100;
        step();
        chk("neg_lo", 64'(evt_data[31:0]),  64'hFFFFFF9C);
        chk("neg_hi", 64'(evt_data[63:32]), 64'd20);
        trg = 1'b0;
        step();

        // Dead time 4 with edges at 10, 13, 15
        do_reset();
        evt_ready = 1'b0;
        deadtime  = 16'd4;
        for (int c = 0; c < 20; c++) begin
            trg  = (c == 10 || c == 13 || c == 15);
            qsum = 29'(c);
            step();
        end
        trg = 1'b0;
        chk("dead_level", 64'(fifo_level), 64'd2);
        chk("dead_cnt",   64'(evt_cnt),    64'd2);
        chk("dead_drop",  64'(drop_cnt),   64'd0);
        chk("dead_ev0",   evt_data, 64'h0000000A_0000000A);
        evt_ready = 1'b1;
        step();
        chk("dead_ev1",   evt_data, 64'h0000000F_0000000F);
        step();
        chk("dead_empty", 64'(evt_valid), 64'd0);
        deadtime = 16'd0;

        // Overflow: 18 pulses into 16 entries, pulse i at timestamp 2i+1
        do_reset();
        evt_ready = 1'b0;
        step();
        for (int i = 0; i < 18; i++) pulse(29'(i));
        chk("ovf_level", 64'(fifo_level), 64'd16);
        chk("ovf_cnt",   64'(evt_cnt),    64'd16);
        chk("ovf_drop",  64'(drop_cnt),   64'd2);
        chk("ovf_head",  evt_data, 64'h00000001_00000000);

        // Full FIFO with simultaneous pop and new edge at timestamp 37
        trg       = 1'b1;
        qsum      = 29'sd77;
        evt_ready = 1'b1;
        step();
        trg = 1'b0;
        chk("fullpop_level", 64'(fifo_level), 64'd16);
        chk("fullpop_drop",  64'(drop_cnt),   64'd2);
        chk("fullpop_cnt",   64'(evt_cnt),    64'd17);
        chk("fullpop_head",  evt_data, 64'h00000003_00000001);

        // Drain in timestamp order
        for (int k = 0; k < 16; k++) begin
            logic [63:0] exp_w;
            exp_w = (k < 15) ? {32'(2 * k + 3), 32'(k + 1)} : 64'h00000025_0000004D;
            chk($sformatf("drain_%0d", k), evt_data, exp_w);
            step();
        end
        chk("drain_valid", 64'(evt_valid), 64'd0);
        chk("drain_level", 64'(fifo_level), 64'd0);

        // Trigger held high across reset release
        trg  = 1'b1;
        qsum = 29'sd3;
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        repeat (3) step();
        chk("hold_level", 64'(fifo_level), 64'd0);
        chk("hold_cnt",   64'(evt_cnt),    64'd0);
        trg = 1'b0;

        // Edge while disabled
        do_reset();
        evt_ready = 1'b0;
        step();
        enable = 1'b0;
        pulse(29'sd9);
        chk("dis_level", 64'(fifo_level), 64'd0);
        chk("dis_cnt",   64'(evt_cnt),    64'd0);
        chk("dis_drop",  64'(drop_cnt),   64'd0);
        enable = 1'b1;

        // Reset with 3 queued entries, then timestamp restarts
        do_reset();
        step();
        pulse(29'sd1);
        pulse(29'sd2);
        pulse(29'sd3);
        chk("rq_level_pre", 64'(fifo_level), 64'd3);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("rq_level", 64'(fifo_level), 64'd0);
        chk("rq_valid", 64'(evt_valid),  64'd0);
        step();
        trg  = 1'b1;
        qsum = 29'sd5;
        step();
        trg = 1'b0;
        chk("rq_ts_restart", evt_data, 64'h00000001_00000005);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
